// File: rtl/io_write_buffer.sv
// UART TX write buffer between the CPU memory bus and RAM/IO.
// IO_WBUF_DROP_NUL_EN: discard TX writes of 0x00 instead of queueing them.
module io_write_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  input  logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUF,
    S_FULL
  } state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  state_t        r_state;

  logic          w_sel;
  logic          w_tx;
  logic          w_stop;
  logic          w_nul;
  logic          w_full;
  logic          w_empty;
  logic          w_act;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_nxt;

  assign w_sel   = cpu_wr && (cpu_a[17:16] == 2'b11);
  assign w_tx    = w_sel && (cpu_a[2:0] == 3'd0);
  assign w_stop  = w_sel && (cpu_a[2:0] == 3'd4);
  assign w_full  = (r_state == S_FULL);
  assign w_empty = (r_state == S_IDLE);
  assign w_act   = rdy_in && !rst_in;

`ifdef IO_WBUF_DROP_NUL_EN
  assign w_nul = w_tx && (cpu_dout == 8'h00);
`else
  assign w_nul = 1'b0;
`endif

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign w_push = w_act && w_tx && !w_full && !w_nul;
  assign w_pop  = w_act && !w_empty && !io_buffer_full;

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CW'(1);
      2'b01:   w_cnt_nxt = r_cnt - CW'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_state <= S_IDLE;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_cnt <= w_cnt_nxt;
      if (w_cnt_nxt == '0)
        r_state <= S_IDLE;
      else if (w_cnt_nxt == CW'(DEPTH))
        r_state <= S_FULL;
      else
        r_state <= S_BUF;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wptr] <= cpu_dout;
  end

  assign tx_data  = r_mem[r_rptr];
  assign tx_valid = !w_empty && !rst_in;
  assign cpu_din  = ram_din;

  // TX writes never reach the bus: a stray access to 0x30000 would eat a UART byte.
  always_comb begin
    ram_a    = cpu_a;
    ram_dout = cpu_dout;
    ram_wr   = cpu_wr && rdy_in;
    cpu_rdy  = rdy_in;
    if (rst_in) begin
      ram_a    = '0;
      ram_dout = '0;
      ram_wr   = 1'b0;
      cpu_rdy  = 1'b0;
    end else if (w_tx) begin
      ram_a   = '0;
      ram_wr  = 1'b0;
      cpu_rdy = rdy_in && (!w_full || w_nul);
    end else if (w_stop && !w_empty) begin
      ram_a   = '0;
      ram_wr  = 1'b0;
      cpu_rdy = 1'b0;
    end
  end

endmodule

// File: doc/io_write_buffer.md
# io_write_buffer

Buffers CPU byte writes to the UART output port (0x30000) in a small FIFO and drains them to the UART at the UART's own pace, so the core is stalled only when the FIFO is full. It sits directly downstream of the `cpu` memory bus (`mem_a`/`mem_dout`/`mem_wr`/`mem_din`) and upstream of RAM and the I/O decoder. It also drives the core's `rdy_in`. All other accesses pass straight through.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset; one clock; reset is synchronous and active-high.
- `rdy_in`  in  1  board ready; low freezes the whole block.
- `cpu_a`  in  32  CPU address bus (`mem_a`).
- `cpu_dout`  in  8  CPU write data (`mem_dout`).
- `cpu_wr`  in  1  CPU write strobe (`mem_wr`).
- `cpu_din`  out  8  read data to CPU; always equals `ram_din`.
- `cpu_rdy`  out  1  to CPU `rdy_in`; low pauses the core.
- `ram_a`  out  32  address to RAM/IO.
- `ram_dout`  out  8  write data to RAM/IO.
- `ram_wr`  out  1  write strobe to RAM/IO.
- `ram_din`  in  8  read data from RAM/IO.
- `io_buffer_full`  in  1  UART transmit buffer full.
- `tx_data`  out  8  byte to UART transmitter.
- `tx_valid`  out  1  `tx_data` is valid.

## Operation
- **TX write:** `cpu_wr`=1, `cpu_a[17:16]`=2'b11, `cpu_a[2:0]`=0.
- **STOP write:** `cpu_wr`=1, `cpu_a[17:16]`=2'b11, `cpu_a[2:0]`=4.
- **Pass-through:** every other cycle. `ram_a`/`ram_dout`/`ram_wr` copy the `cpu_*` signals combinationally.
- **TX write handling:**
  - The cycle is never forwarded: `ram_wr`=0 and `ram_a`=0. This avoids a read of 0x30000 consuming a UART input byte.
  - If `count`<`DEPTH`, `cpu_dout` is pushed at the clock edge and `cpu_rdy`=1.
  - If `count`==`DEPTH`, `cpu_rdy`=0 and no push occurs, even if a pop happens that cycle. The CPU holds its request; the push completes in the first cycle that sees `count`<`DEPTH`.
- **STOP write handling:**
  - While `count`!=0, `cpu_rdy`=0, `ram_wr`=0 and `ram_a`=0.
  - Once `count`==0, the write is forwarded unchanged and `cpu_rdy`=1. Output ordering is therefore preserved before the stop byte.
- **Drain:**
  - `tx_valid`=(`count`!=0) and `tx_data`=FIFO head.
  - A pop occurs at the edge when `tx_valid` && !`io_buffer_full`.
- **Simultaneous push and pop:** allowed; `count` is unchanged and the pointers both advance.
- **Pointers:** read and write pointers are `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`. `count` is `$clog2(DEPTH)+1` bits.
- **Paused (`rdy_in`=0):** `cpu_rdy`=0, `ram_wr`=0, and no push or pop occurs. `tx_valid` still reflects `count`.
- **States:**
  - IDLE: `count`==0.
  - BUFFERING: 0<`count`<`DEPTH`.
  - FULL: `count`==`DEPTH`.
  - STOP_WAIT is a combinational qualifier: STOP write pending with `count`!=0.

## Timing
- **Reset values (rst_in):**
  - `count`=0, pointers=0.
  - `tx_valid`=0, `cpu_rdy`=0, `ram_wr`=0, `ram_a`=0, `ram_dout`=0.
  - `cpu_din` follows `ram_din`.
  - FIFO contents are don't-care.
- **Reset mid-operation:** buffered bytes are discarded.
- **Push to UART:** a byte pushed at edge N gives `tx_valid`=1 with that byte during cycle N+1.
- **Pop:** `tx_data` advances at the edge after the pop cycle.
- **Throughput:** 1 byte/cycle in, 1 byte/cycle out.
- **Pass-through and `cpu_rdy`:** combinational, no added latency. Read data still returns the next cycle, as RAM provides it.
- **STOP forwarding:** earliest in the cycle after the last pop.
- **Byte order:** first-in first-out; no byte is lost or duplicated under any `io_buffer_full` pattern.

## Configuration
- **`IO_WBUF_DROP_NUL_EN` defined:** a TX write of 0x00 completes with `cpu_rdy`=1 even when FIFO is FULL, and is discarded (no push).
- **`IO_WBUF_DROP_NUL_EN` undefined:** 0x00 is treated like any byte (enqueued, stalls when full) and reaches `tx_data`.

## Test plan
- **Single byte:** reset; TX write 0x41 with `io_buffer_full`=0.
  - Next cycle: `tx_valid`=1, `tx_data`=0x41.
  - Cycle after: `tx_valid`=0.
  - `ram_wr` stays 0 throughout.
- **Fill and stall:** hold `io_buffer_full`=1; issue 9 TX writes 0x01..0x09 (DEPTH=8).
  - First 8 accepted; 9th sees `cpu_rdy`=0.
  - Release `io_buffer_full` → 0x09 accepted the cycle after the first pop.
  - `tx_data` sequence is 0x01..0x09.
- **Wrap-around:** 20 bytes pushed while draining, `io_buffer_full` toggling every 3 cycles → all 20 bytes emerge in order; `count` never exceeds 8.
- **STOP ordering:** 3 bytes buffered with `io_buffer_full`=1, then a STOP write.
  - `cpu_rdy`=0 and `ram_wr`=0 until all 3 bytes are popped.
  - Then `ram_a`=0x30004 and `ram_wr`=1 for one cycle.
- **Pass-through:** RAM write addr 0x100 data 0x5A, then read 0x100 → `ram_*` equal `cpu_*` in the same cycle; `cpu_din`=`ram_din`.
- **NUL, macro on/off:** FIFO full, TX write 0x00.
  - Macro defined: `cpu_rdy`=1, `count` stays 8.
  - Macro undefined: stall, then 0x00 later appears on `tx_data`.
